// File: rtl/probador_sint_mult_div.sv
// probador_sint_mult_div: LFSR-driven go/done sequencer that runs a UUT and a reference unit in lockstep and compares them.
// Latency: start to first go is 3 cycles when both done inputs are already low; every output is registered.
// Backpressure: waits for both done inputs (low before go, high after go); each wait is bounded by TIMEOUT cycles.
// Optional feature: define ABORT_ON_ERR_EN to end the run at the first mismatching operation.
module probador_sint_mult_div #(
  parameter int          W_A         = 32,
  parameter int          W_B         = 16,
  parameter int          NUM_PRUEBAS = 20,
  parameter logic [31:0] SEED        = 32'h1,
  parameter int          TIMEOUT     = 64
) (
  input  logic           clk,
  input  logic           reset_L,
  input  logic           start,
  output logic [W_A-1:0] ent_a,
  output logic [W_B-1:0] ent_b,
  output logic           go,
  output logic           div_mult,
  input  logic [W_A-1:0] sal_ideal,
  input  logic           done_ideal,
  input  logic [W_A-1:0] sal,
  input  logic           done,
  output logic           busy,
  output logic           fin,
  output logic           pass,
  output logic [15:0]    err_count,
  output logic [15:0]    prueba_idx,
  output logic           timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_LOW, S_GO, S_WAIT_DONE, S_CHECK, S_END
  } state_t;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] TAPS     = 32'h80200003;
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_lfsr;
  logic [TW-1:0]   r_tmo_cnt;
  logic [W_A-1:0]  r_ent_a;
  logic [W_B-1:0]  r_ent_b;
  logic            r_go;
  logic            r_div_mult;
  logic            r_busy;
  logic            r_fin;
  logic            r_pass;
  logic [15:0]     r_err;
  logic [15:0]     r_idx;
  logic            r_tmo;
  logic            r_mis;

  logic [31:0]     w_lfsr_nxt;
  logic [W_B-1:0]  w_ent_b_raw;
  logic            w_both_low;
  logic            w_both_high;
  logic            w_tmo_hit;
  logic            w_last;
  logic            w_restart;
  logic            w_timeout;
  logic            w_enter_end;
  logic [15:0]     w_err_inc;

  assign w_lfsr_nxt  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'h0);
  assign w_ent_b_raw = r_lfsr[31:32-W_B];
  assign w_both_low  = !done && !done_ideal;
  assign w_both_high = done && done_ideal;
  assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
  assign w_last      = ((r_idx + 16'd1) == 16'(NUM_PRUEBAS));
  assign w_restart   = ((r_state == S_IDLE) || (r_state == S_END)) && start;
  assign w_enter_end = (w_state_nxt == S_END) && (r_state != S_END);
  assign w_err_inc   = (r_err == 16'hFFFF) ? r_err : (r_err + 16'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_L) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and timeout detection.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_LOAD;
      S_LOAD:      w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (w_both_low) begin
          w_state_nxt = S_GO;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_END;
          w_timeout   = 1'b1;
        end
      end
      S_GO:        w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (w_both_high) begin
          w_state_nxt = S_CHECK;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_END;
          w_timeout   = 1'b1;
        end
      end
      S_CHECK: begin
`ifdef ABORT_ON_ERR_EN
        w_state_nxt = (w_last || r_mis) ? S_END : S_LOAD;
`else
        w_state_nxt = w_last ? S_END : S_LOAD;
`endif
      end
      S_END:       if (start) w_state_nxt = S_LOAD;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operands, handshake, comparison, counters and run status.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_lfsr     <= SEED_EFF;
      r_tmo_cnt  <= '0;
      r_ent_a    <= '0;
      r_ent_b    <= '0;
      r_go       <= 1'b0;
      r_div_mult <= 1'b0;
      r_busy     <= 1'b0;
      r_fin      <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_idx      <= '0;
      r_tmo      <= 1'b0;
      r_mis      <= 1'b0;
    end else begin
      // The counter restarts whenever either wait state is (re)entered.
      if ((r_state == S_WAIT_LOW) || (r_state == S_WAIT_DONE)) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      else                                                     r_tmo_cnt <= '0;

      if (w_restart) begin
        r_busy     <= 1'b1;
        r_fin      <= 1'b0;
        r_pass     <= 1'b0;
        r_lfsr     <= SEED_EFF;
        r_err      <= '0;
        r_idx      <= '0;
        r_tmo      <= 1'b0;
        r_mis      <= 1'b0;
        r_div_mult <= 1'b0;
      end

      case (r_state)
        S_LOAD: begin
          r_go       <= 1'b0;
          r_div_mult <= ~r_div_mult;
          r_ent_a    <= r_lfsr[W_A-1:0];
          // Current op multiply means the new op is a divide: never divide by zero.
          r_ent_b    <= (r_div_mult && (w_ent_b_raw == '0)) ? W_B'(1) : w_ent_b_raw;
          r_lfsr     <= w_lfsr_nxt;
        end
        S_GO:        r_go <= 1'b1;
        S_WAIT_DONE: if (w_both_high) r_mis <= (sal != sal_ideal);
        S_CHECK: begin
          r_go  <= 1'b0;
          r_idx <= r_idx + 16'd1;
          if (r_mis) r_err <= w_err_inc;
        end
        default: ;
      endcase

      if (w_timeout) begin
        r_go  <= 1'b0;
        r_tmo <= 1'b1;
      end

      // A mismatch being counted this cycle already rules out a pass.
      if (w_enter_end) begin
        r_busy <= 1'b0;
        r_fin  <= 1'b1;
        r_pass <= !w_timeout && !r_tmo && (r_err == 16'd0) && !((r_state == S_CHECK) && r_mis);
      end
    end
  end

  assign ent_a       = r_ent_a;
  assign ent_b       = r_ent_b;
  assign go          = r_go;
  assign div_mult    = r_div_mult;
  assign busy        = r_busy;
  assign fin         = r_fin;
  assign pass        = r_pass;
  assign err_count   = r_err;
  assign prueba_idx  = r_idx;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_probador_sint_mult_div.sv
// tb_probador_sint_mult_div: drives probador_sint_mult_div with two emulated go/done units.
// Operands, handshake timing and final status are compared against a behavioural model of the run.
// Unit response delays, injected mismatches, stuck units and pre-held done levels are randomized.
module tb_probador_sint_mult_div;
  localparam int          W_A  = 32;
  localparam int          W_B  = 16;
  localparam int          NP   = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] SEED = 32'h2;

  logic           clk = 1'b0;
  logic           reset_L = 1'b0;
  logic           start = 1'b0;
  logic [W_A-1:0] ent_a;
  logic [W_B-1:0] ent_b;
  logic           go;
  logic           div_mult;
  logic [W_A-1:0] sal_ideal = '0;
  logic           done_ideal = 1'b0;
  logic [W_A-1:0] sal = '0;
  logic           done = 1'b0;
  logic           busy;
  logic           fin;
  logic           pass;
  logic [15:0]    err_count;
  logic [15:0]    prueba_idx;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  probador_sint_mult_div #(
    .W_A(W_A), .W_B(W_B), .NUM_PRUEBAS(NP), .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_L(reset_L), .start(start),
    .ent_a(ent_a), .ent_b(ent_b), .go(go), .div_mult(div_mult),
    .sal_ideal(sal_ideal), .done_ideal(done_ideal), .sal(sal), .done(done),
    .busy(busy), .fin(fin), .pass(pass), .err_count(err_count),
    .prueba_idx(prueba_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ent_a"}, ent_a, 0);
    check_val({tag, "_ent_b"}, ent_b, 0);
    check_val({tag, "_flags"}, {go, div_mult, busy, fin, pass, timeout_err, err_count, prueba_idx}, 0);
  endtask

  // One complete run: bad[i] corrupts the UUT result of op i, stuck_op freezes the UUT done
  // on that op (-1 for none), hold_ideal keeps done_ideal high before the first go.
  task automatic do_run(input logic [NP-1:0] bad, input int stuck_op, input bit hold_ideal);
    logic [31:0] l, a, b, r;
    bit          dm, tmo;
    int          idx, errs, du, di, n;
    l = (SEED == 32'h0) ? 32'h1 : SEED;
    dm = 1'b0; tmo = 1'b0; idx = 0; errs = 0;
    done = 1'b0;
    done_ideal = hold_ideal;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    for (int i = 0; i < NP; i++) begin
      dm = !dm;
      a = l;
      b = {16'h0, l[31:16]};
      if (!dm && b == 32'h0) b = 32'h1;
      l = lfsr_step(l);
      if (i == 0 && hold_ideal) begin
        repeat (5) tick();
        check_val("hold_go_low", go, 0);
        done_ideal = 1'b0;
        tick();
        check_val("release_go_low", go, 0);
        tick();
        check_val("release_go_2cyc", go, 1);
      end else if (i == 0) begin
        tick();
        tick();
        check_val("lat_go_low", go, 0);
        tick();
        check_val("lat_go_3cyc", go, 1);
      end else begin
        n = 0;
        while (go !== 1'b1 && n < 40) begin
          tick();
          n++;
        end
        check_val("go_wait_bound", go, 1);
      end
      check_val("ent_a", ent_a, a);
      check_val("ent_b", ent_b, b[15:0]);
      check_val("div_mult", div_mult, dm);
      r = dm ? (a * b) : (a / b);
      if (i == stuck_op) begin
        di = $urandom_range(0, 3);
        n = 0;
        while (go === 1'b1 && n < 40) begin
          if (n >= di) begin
            done_ideal = 1'b1;
            sal_ideal  = r;
          end
          tick();
          n++;
        end
        check_val("tmo_go_cycles", n, TMO);
        tmo = 1'b1;
        done_ideal = 1'b0;
        break;
      end
      du = $urandom_range(0, 4);
      di = $urandom_range(0, 4);
      sal = $urandom();
      sal_ideal = $urandom();
      n = 0;
      while (n < 40) begin
        if (n >= du) begin
          done = 1'b1;
          sal  = r ^ {31'h0, bad[i]};
        end
        if (n >= di) begin
          done_ideal = 1'b1;
          sal_ideal  = r;
        end
        tick();
        n++;
        if (n > du && n > di) break;
      end
      n = 0;
      while (go === 1'b1 && n < 10) begin
        tick();
        n++;
      end
      check_val("go_drop", go, 0);
      done = 1'b0;
      done_ideal = 1'b0;
      idx++;
      if (bad[i]) errs++;
`ifdef ABORT_ON_ERR_EN
      if (bad[i]) break;
`endif
    end
    n = 0;
    while (fin !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("end_fin", fin, 1);
    check_val("end_busy", busy, 0);
    check_val("end_go", go, 0);
    check_val("end_pass", pass, (errs == 0) && !tmo);
    check_val("end_err_count", err_count, errs);
    check_val("end_prueba_idx", prueba_idx, idx);
    check_val("end_timeout_err", timeout_err, tmo);
  endtask

  initial begin
    int n;
    logic [NP-1:0] m;
    reset_L = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset");
    reset_L = 1'b1;
    tick();
    check_val("idle_busy", busy, 0);

    do_run('0, -1, 1'b0);                 // clean run
    do_run(4'b0010, -1, 1'b0);            // mismatch on op 2
    do_run('0, 0, 1'b0);                  // UUT done stuck on first op
    do_run('0, -1, 1'b1);                 // done_ideal held before the run

    // Reset in the middle of WAIT_DONE, then an identical run from the seed.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (go !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("pre_reset_go", go, 1);
    done_ideal = 1'b1;
    tick();
    reset_L = 1'b0;
    tick();
    check_reset_outputs("midrun_reset");
    reset_L = 1'b1;
    done_ideal = 1'b0;
    tick();
    do_run('0, -1, 1'b0);

    repeat (8) begin
      m = '0;
      for (int k = 0; k < NP; k++) m[k] = ($urandom_range(0, 3) == 0);
      do_run(m, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : -1,
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
